// File: rtl/button_event_scheduler.sv
// Button event scheduler: turns debounced button levels into press/release/long-press/repeat
// events, arbitrated round-robin onto one valid/ready port. Latency: edge -> evt_valid in 2 cycles.
// Backpressure: one pending slot per button; a post to a busy slot is dropped and sets overflow.
// Build option: define BUTTON_EVENT_REPEAT_EN to emit repeat events while a button stays held.
module button_event_scheduler #(
  parameter int N_BUTTONS    = 4,
  parameter int TICK_CYCLES  = 200_000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_BUTTONS-1:0]         btn_clean,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [$clog2(N_BUTTONS)-1:0] evt_btn,
  output logic [1:0]                   evt_type,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int BW        = $clog2(N_BUTTONS);
  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [1:0] ST_LOCKED  = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_HELD    = 2'd3;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [1:0]    EVT_REPEAT  = 2'd3;
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
`endif

  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_TICKS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]                r_presc;
  logic                         w_tick;
  logic [N_BUTTONS-1:0]         r_btn_prev;
  logic [N_BUTTONS-1:0]         w_rise;
  logic [N_BUTTONS-1:0]         w_fall;
  logic [N_BUTTONS-1:0][1:0]    r_state;
  logic [N_BUTTONS-1:0][1:0]    w_state_nxt;
  logic [N_BUTTONS-1:0][CW-1:0] r_cnt;
  logic [N_BUTTONS-1:0][CW-1:0] w_cnt_nxt;
  logic [N_BUTTONS-1:0]         w_post;
  logic [N_BUTTONS-1:0][1:0]    w_post_typ;
  logic [N_BUTTONS-1:0]         r_slot_vld;
  logic [N_BUTTONS-1:0][1:0]    r_slot_typ;
  logic [N_BUTTONS-1:0]         w_gnt_sel;
  logic [N_BUTTONS-1:0]         w_drop;
  logic                         w_take;
  logic                         w_gnt_vld;
  logic [BW-1:0]                w_gnt_idx;
  logic [BW-1:0]                w_ptr_nxt;
  logic [BW-1:0]                r_ptr;
  logic                         r_evt_vld;
  logic [BW-1:0]                r_evt_btn;
  logic [1:0]                   r_evt_typ;
  logic                         r_ovf;

  // Modular add for button indices, which need not be a power of two.
  function automatic logic [BW-1:0] wrap_add(input logic [BW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_BUTTONS) s = s - N_BUTTONS;
    return BW'(s);
  endfunction

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_rise = btn_clean & ~r_btn_prev;
  assign w_fall = ~btn_clean & r_btn_prev;

  // Free-running prescaler shared by every hold timer.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Per-button event FSM: next state, hold counter and event to post.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_post      = '0;
    w_post_typ  = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      case (r_state[i])
        ST_LOCKED: begin
          if (w_fall[i]) w_state_nxt[i] = ST_IDLE;
        end
        ST_IDLE: begin
          if (w_rise[i]) begin
            w_post[i]      = 1'b1;
            w_post_typ[i]  = EVT_PRESS;
            w_cnt_nxt[i]   = '0;
            w_state_nxt[i] = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (w_fall[i]) begin
            w_post[i]      = 1'b1;
            w_post_typ[i]  = EVT_RELEASE;
            w_state_nxt[i] = ST_IDLE;
          end else if (w_tick) begin
            if (r_cnt[i] >= LONG_LAST) begin
              w_post[i]      = 1'b1;
              w_post_typ[i]  = EVT_LONG;
              w_cnt_nxt[i]   = '0;
              w_state_nxt[i] = ST_HELD;
            end else if (r_cnt[i] != CNT_MAX) begin
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
          end
        end
        default: begin
          if (w_fall[i]) begin
            w_post[i]      = 1'b1;
            w_post_typ[i]  = EVT_RELEASE;
            w_state_nxt[i] = ST_IDLE;
          end
`ifdef BUTTON_EVENT_REPEAT_EN
          else if (w_tick) begin
            if (r_cnt[i] >= REPEAT_LAST) begin
              w_post[i]     = 1'b1;
              w_post_typ[i] = EVT_REPEAT;
              w_cnt_nxt[i]  = '0;
            end else if (r_cnt[i] != CNT_MAX) begin
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
          end
`endif
        end
      endcase
    end
  end

  // Button state registers; buttons held through reset start LOCKED so reset makes no events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_prev <= btn_clean;
      r_cnt      <= '0;
      for (int i = 0; i < N_BUTTONS; i++) r_state[i] <= btn_clean[i] ? ST_LOCKED : ST_IDLE;
    end else begin
      r_btn_prev <= btn_clean;
      r_cnt      <= w_cnt_nxt;
      r_state    <= w_state_nxt;
    end
  end

  // Round-robin pick: lowest-offset valid slot at or after the pointer wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int off = N_BUTTONS - 1; off >= 0; off--) begin
      if (r_slot_vld[wrap_add(r_ptr, off)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = wrap_add(r_ptr, off);
      end
    end
  end

  assign w_take    = ~r_evt_vld | evt_ready;
  assign w_ptr_nxt = wrap_add(w_gnt_idx, 1);

  // A post only drops when its slot is full and that slot is not leaving this cycle.
  always_comb begin
    w_gnt_sel = '0;
    w_drop    = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      w_gnt_sel[i] = w_take & w_gnt_vld & (w_gnt_idx == BW'(i));
      w_drop[i]    = w_post[i] & r_slot_vld[i] & ~w_gnt_sel[i];
    end
  end

  // Pending slots: load on accepted post, clear on grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot_vld <= '0;
      r_slot_typ <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (w_post[i] && !w_drop[i]) begin
          r_slot_vld[i] <= 1'b1;
          r_slot_typ[i] <= w_post_typ[i];
        end else if (w_gnt_sel[i]) begin
          r_slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Output register: refills whenever empty or being accepted, otherwise holds stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_evt_vld <= 1'b0;
      r_evt_btn <= '0;
      r_evt_typ <= '0;
      r_ptr     <= '0;
    end else if (w_take) begin
      r_evt_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_evt_btn <= w_gnt_idx;
        r_evt_typ <= r_slot_typ[w_gnt_idx];
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n)            r_ovf <= 1'b0;
    else if (|w_drop)      r_ovf <= 1'b1;
    else if (clr_overflow) r_ovf <= 1'b0;
  end

  assign evt_valid = r_evt_vld;
  assign evt_btn   = r_evt_btn;
  assign evt_type  = r_evt_typ;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed scenarios then random button/ready/clear/reset
// traffic, compared every cycle against a tick-counting event model with a slot/arbiter scoreboard.
module tb_button_event_scheduler;

  localparam int N    = 4;
  localparam int TICK = 4;
  localparam int LONG = 5;
  localparam int REP  = 2;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_clean = '0;
  logic         evt_valid;
  logic         evt_ready = 1'b1;
  logic [1:0]   evt_btn;
  logic [1:0]   evt_type;
  logic         overflow;
  logic         clr_overflow = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  button_event_scheduler #(
    .N_BUTTONS(N), .TICK_CYCLES(TICK), .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_clean(btn_clean),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn),
    .evt_type(evt_type), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_init = 1'b0;
  int         m_n;
  bit         m_prev    [N];
  bit         m_locked  [N];
  bit         m_pressed [N];
  int         m_ticks   [N];
  bit         m_pend    [N];
  logic [1:0] m_ptype   [N];
  bit         m_post    [N];
  logic [1:0] m_pnew    [N];
  int         m_ptr;
  bit         m_ovld;
  int         m_obtn;
  logic [1:0] m_otyp;
  bit         m_ovf;

  always @(posedge clk) begin : model
    int g;
    bit take, drop, tk;
    if (!rst_n) begin
      m_init = 1'b1; m_n = 0; m_ptr = 0;
      m_ovld = 1'b0; m_obtn = 0; m_otyp = 2'd0; m_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0; m_prev[i] = btn_clean[i]; m_locked[i] = btn_clean[i];
        m_pressed[i] = 1'b0; m_ticks[i] = 0;
      end
    end else if (m_init) begin
      tk = (m_n % TICK) == TICK - 1;
      m_n++;
      // events: ticks are counted since the press, long-press at LONG, repeats every REP after
      for (int i = 0; i < N; i++) begin
        m_post[i] = 1'b0; m_pnew[i] = 2'd0;
        if (m_locked[i]) begin
          if (!btn_clean[i]) m_locked[i] = 1'b0;
        end else if (!m_pressed[i]) begin
          if (btn_clean[i] && !m_prev[i]) begin
            m_post[i] = 1'b1; m_pnew[i] = 2'd0; m_pressed[i] = 1'b1; m_ticks[i] = 0;
          end
        end else if (!btn_clean[i]) begin
          m_post[i] = 1'b1; m_pnew[i] = 2'd1; m_pressed[i] = 1'b0;
        end else if (tk) begin
          m_ticks[i]++;
          if (m_ticks[i] == LONG) begin
            m_post[i] = 1'b1; m_pnew[i] = 2'd2;
          end else if (REP_EN && m_ticks[i] > LONG && ((m_ticks[i] - LONG) % REP) == 0) begin
            m_post[i] = 1'b1; m_pnew[i] = 2'd3;
          end
        end
        m_prev[i] = btn_clean[i];
      end
      // arbitration from the slot contents before this cycle's posts
      take = !m_ovld || evt_ready;
      g = -1;
      if (take) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) begin
          m_ovld = 1'b1; m_obtn = g; m_otyp = m_ptype[g]; m_ptr = (g + 1) % N;
          m_pend[g] = 1'b0;
        end else begin
          m_ovld = 1'b0;
        end
      end
      drop = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_post[i]) begin
          if (m_pend[i]) drop = 1'b1;
          else begin m_pend[i] = 1'b1; m_ptype[i] = m_pnew[i]; end
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
    end
  end

  // accepted-event log and per-cycle comparison against the model
  logic [7:0] log_q [$];
  logic [7:0] want_q [$];

  always @(negedge clk) begin
    if (m_init) begin
      check("evt_valid", evt_valid, m_ovld);
      if (m_ovld) begin
        check("evt_btn", evt_btn, m_obtn);
        check("evt_type", evt_type, m_otyp);
      end
      check("overflow", overflow, m_ovf);
      if (rst_n && evt_valid && evt_ready) log_q.push_back({4'h0, evt_btn, evt_type});
    end
  end

  function automatic logic [7:0] ev(input int b, input int t);
    return 8'(b * 4 + t);
  endfunction

  task automatic check_log(input string tag);
    check({tag, "_cnt"}, log_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < log_q.size(); i++) check(tag, log_q[i], want_q[i]);
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();
  endtask

  initial begin
    // 1: button held through reset stays silent until released and pressed again
    btn_clean = 4'b0010;
    repeat (3) nxt();
    rst_n = 1'b1;
    check("rst_valid", evt_valid, 0);
    check("rst_btn", evt_btn, 0);
    check("rst_type", evt_type, 0);
    check("rst_ovf", overflow, 0);
    repeat (3) nxt();
    btn_clean[1] = 1'b0;
    repeat (4) nxt();
    check("locked_quiet", evt_valid, 0);
    check("locked_log", log_q.size(), 0);
    btn_clean[1] = 1'b1;
    repeat (4) nxt();
    btn_clean[1] = 1'b0;
    repeat (4) nxt();
    want_q = {ev(1, 0), ev(1, 1)};
    check_log("locked_seq");

    // 2: edge-to-event latency for press and release
    btn_clean[2] = 1'b1;
    nxt();
    check("press_lat1", evt_valid, 0);
    nxt();
    check("press_lat2", evt_valid, 1);
    check("press_btn", evt_btn, 2);
    check("press_type", evt_type, 0);
    repeat (3) nxt();
    btn_clean[2] = 1'b0;
    nxt();
    check("rel_lat1", evt_valid, 0);
    nxt();
    check("rel_lat2", evt_valid, 1);
    check("rel_btn", evt_btn, 2);
    check("rel_type", evt_type, 1);
    repeat (3) nxt();

    // 3: long hold produces long-press and, when enabled, repeats
    log_q.delete();
    btn_clean[0] = 1'b1;
    repeat (40) nxt();
    btn_clean[0] = 1'b0;
    repeat (5) nxt();
    if (REP_EN) want_q = {ev(0, 0), ev(0, 2), ev(0, 3), ev(0, 3), ev(0, 1)};
    else        want_q = {ev(0, 0), ev(0, 2), ev(0, 1)};
    check_log("hold_seq");

    // 4: simultaneous presses drain one per cycle in round-robin order
    do_reset();
    log_q.delete();
    btn_clean = 4'b1111;
    nxt();
    for (int k = 0; k < N; k++) begin
      nxt();
      check("burst_vld", evt_valid, 1);
      check("burst_btn", evt_btn, k);
    end
    repeat (2) nxt();
    btn_clean = 4'b1011;
    repeat (3) nxt();
    btn_clean = 4'b0000;
    repeat (6) nxt();
    want_q = {ev(0, 0), ev(1, 0), ev(2, 0), ev(3, 0), ev(2, 1), ev(3, 1), ev(0, 1), ev(1, 1)};
    check_log("rr_seq");

    // 5: backpressure holds output, fills the slot, then drops and flags overflow
    evt_ready = 1'b0;
    do_reset();
    log_q.delete();
    btn_clean[1] = 1'b1;
    repeat (2) nxt();
    check("bp_vld", evt_valid, 1);
    check("bp_btn", evt_btn, 1);
    check("bp_type", evt_type, 0);
    check("bp_ovf0", overflow, 0);
    btn_clean[1] = 1'b0;
    repeat (2) nxt();
    check("bp_hold_type", evt_type, 0);
    check("bp_ovf1", overflow, 0);
    btn_clean[1] = 1'b1;
    nxt();
    check("bp_drop_ovf", overflow, 1);
    nxt();
    check("bp_hold_vld", evt_valid, 1);
    check("bp_hold_btn", evt_btn, 1);
    clr_overflow = 1'b1;
    nxt();
    clr_overflow = 1'b0;
    check("bp_clr", overflow, 0);
    evt_ready = 1'b1;
    repeat (4) nxt();
    want_q = {ev(1, 0), ev(1, 1)};
    check_log("bp_seq");
    btn_clean[1] = 1'b0;
    repeat (4) nxt();

    // 6: reset with an event in flight and slots pending discards everything
    evt_ready = 1'b0;
    btn_clean = 4'b0111;
    repeat (2) nxt();
    check("pre_rst_vld", evt_valid, 1);
    rst_n = 1'b0;
    nxt();
    check("mid_rst_vld", evt_valid, 0);
    check("mid_rst_ovf", overflow, 0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    log_q.delete();
    repeat (10) nxt();
    check("post_rst_quiet", log_q.size(), 0);
    btn_clean = 4'b0000;
    repeat (6) nxt();
    check("post_rst_locked", log_q.size(), 0);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 23) == 0) btn_clean[i] = ~btn_clean[i];
      evt_ready    = ($urandom_range(0, 9) < 7);
      clr_overflow = ($urandom_range(0, 31) == 0);
      rst_n        = ($urandom_range(0, 499) != 0);
      nxt();
    end
    rst_n = 1'b1;
    evt_ready = 1'b1;
    clr_overflow = 1'b0;
    repeat (4) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Sits downstream of the per-button debouncers in the front-panel input path.
- Turns N debounced button levels into discrete press, release, long-press and auto-repeat events.
- Arbitrates pending events round-robin onto a single valid/ready event port, consumed by the UI/command logic.
- One free-running prescaler supplies the millisecond tick shared by all buttons' hold timers.

Parameters:
- N_BUTTONS, 4: number of debounced button inputs; legal range 2..16.
- TICK_CYCLES, 200_000: clk cycles per hold-timer tick (1 ms at 5 ns clk).
- LONG_TICKS, 500: ticks a button must stay held before a long-press event; must be ≥ 1.
- REPEAT_TICKS, 100: ticks between repeat events after long-press; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- btn_clean  in  N_BUTTONS  debounced button levels, 1 = pressed; synchronous to clk.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready.
- evt_btn  out  $clog2(N_BUTTONS)  index of the button that produced the event.
- evt_type  out  2  event type: 00 press, 01 release, 10 long-press, 11 repeat.
- overflow  out  1  sticky flag: at least one event was dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge): evt_valid=0, evt_btn=0, evt_type=0, overflow=0.
  - All pending slots clear, prescaler=0, round-robin pointer=0.
  - btn_prev loads btn_clean.
  - Each button whose btn_clean=1 enters LOCKED; every other button enters IDLE.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps.
  - tick is asserted for one cycle when the count is TICK_CYCLES-1.
  - Free-running; not restarted by button activity.
- Per-button FSM (edge = btn_clean vs btn_prev, sampled each cycle):
  - LOCKED: generates no events. On a falling edge → IDLE. Prevents spurious events for buttons held through reset.
  - IDLE: on a rising edge → post press, clear hold_cnt, go to PRESSED.
  - PRESSED:
    - Falling edge → post release, go to IDLE.
    - Otherwise, on tick, increment hold_cnt.
    - When hold_cnt reaches LONG_TICKS → post long-press, clear hold_cnt, go to HELD.
  - HELD:
    - Falling edge → post release, go to IDLE.
    - Otherwise, on tick, increment hold_cnt (repeat behaviour: see Optional Feature).
  - hold_cnt width is $clog2(max(LONG_TICKS,REPEAT_TICKS)+1) and saturates; it never wraps.
- Pending slots:
  - One slot per button, holding a valid bit and a 2-bit type.
  - "Post" sets the slot in the cycle after the edge or threshold.
  - If a post finds the slot occupied and the slot is not being granted in the same cycle: the new event is dropped, the old event is kept, and overflow is set.
  - A grant and a post to the same button in the same cycle: the slot reloads with the new event; overflow is not set.
- Arbiter:
  - When the output register is empty, or is being accepted this cycle, grant the lowest-index valid slot at or after the pointer, with wrap-around.
  - The grant loads evt_btn/evt_type, asserts evt_valid, clears the slot, and sets pointer = granted index + 1 (mod N_BUTTONS).
  - Back-to-back acceptance sustains one event per cycle.
- Handshake:
  - While evt_valid=1 and evt_ready=0, evt_btn and evt_type are held stable.
  - evt_valid never drops without acceptance, except at reset.
- Latency: btn_clean edge at cycle k → slot valid at k+1 → evt_valid at k+2 if the output was idle.
- overflow:
  - Set by any drop; cleared by clr_overflow.
  - A drop coincident with clr_overflow leaves overflow=1 (set wins).
- Reset mid-operation: pending and in-flight events are discarded; no events are generated for the reset itself.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: in HELD, each time hold_cnt reaches REPEAT_TICKS, post a repeat event and clear hold_cnt. Repeats continue until release.
- Undefined: HELD posts nothing until release; evt_type 11 is never produced; the repeat counter logic is removed.
- The REPEAT_TICKS parameter remains legal in both builds.

Test Plan:
Bench parameters for all scenarios: N_BUTTONS=4, TICK_CYCLES=4, LONG_TICKS=5, REPEAT_TICKS=2.
- Reset with btn_clean=4'b0010, release btn1, press btn1 -> only press then release events for btn1; no event for the release while LOCKED.
- Press btn2 at cycle 10 with evt_ready=1 -> evt_valid=1 at cycle 12, evt_btn=2, evt_type=00; release -> type 01 two cycles after the edge.
- Hold btn0 for 40 cycles, macro defined -> press; long-press ~20 cycles later; repeats every 8 cycles; then release. Macro undefined -> press, long-press, release only.
- Press btn0..btn3 in the same cycle, evt_ready=1 -> four events on consecutive cycles, btn order 0,1,2,3; next simultaneous burst starts from the pointer position.
- evt_ready=0 while btn1 press/release/press occurs -> first event held stable; one slot fills; a third post drops and sets overflow=1; clr_overflow returns it to 0.
- Assert rst_n=0 with evt_valid=1 and two slots pending -> next cycle evt_valid=0, overflow=0, no stale events after reset.
